// File: rtl/useq_ctrl.sv
// Microsequencer control unit: micro-PC register, 32x16 writable control
// store with registered read and write bypass, a sticky halt flag and a
// saturating count of executed microinstructions.
module useq_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [4:0]  nextst,
  input  logic        cs_we,
  input  logic [4:0]  cs_waddr,
  input  logic [15:0] cs_wdata,
  output logic [4:0]  state,
  output logic [15:0] cword,
  output logic [1:0]  nssel,
  output logic [4:0]  dbin,
  output logic [7:0]  ctl,
  output logic        valid,
  output logic        halt,
  output logic [7:0]  ucount
);

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_HALT = 1'b1
  } mode_t;

  mode_t       mode_reg, mode_next;
  logic [15:0] store_mem [0:31];
  logic [4:0]  state_reg;
  logic [15:0] cword_reg;
  logic        valid_reg;
  logic [7:0]  ucount_reg;

  logic        halt_hit;
  logic        advance;
  logic        count_en;
  logic [15:0] load_word;

  // Halt detection, advance qualification, run/halt next mode and the
  // bypassed control-store read for the word loaded on this edge.
  always_comb begin
    halt_hit  = 1'b0;
    advance   = 1'b0;
    mode_next = mode_reg;
    if (mode_reg == MODE_RUN) begin
      // A valid word carrying the halt bit stops the sequencer in place:
      // state/cword stay on the halting word, but it is still counted.
      halt_hit = valid_reg && cword_reg[7] && !stall;
      advance  = !stall && !halt_hit;
      if (halt_hit) begin
        mode_next = MODE_HALT;
      end
    end
    count_en  = (advance && valid_reg) || halt_hit;
    load_word = (cs_we && (cs_waddr == nextst)) ? cs_wdata : store_mem[nextst];
  end

  // Control store writes; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (cs_we) begin
      store_mem[cs_waddr] <= cs_wdata;
    end
  end

  // Run/halt mode register; halt is sticky until reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_reg <= MODE_RUN;
    end else begin
      mode_reg <= mode_next;
    end
  end

  // Micro-PC, registered control word and valid flag; the reset bubble
  // leaves cword at zero so the first advance fetches store[0].
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= 5'd0;
      cword_reg <= 16'h0000;
      valid_reg <= 1'b0;
    end else if (advance) begin
      state_reg <= nextst;
      cword_reg <= load_word;
      valid_reg <= 1'b1;
    end
  end

  // Saturating executed-microinstruction counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      ucount_reg <= 8'd0;
    end else if (count_en && (ucount_reg != 8'hFF)) begin
      ucount_reg <= ucount_reg + 8'd1;
    end
  end

  assign state  = state_reg;
  assign cword  = cword_reg;
  assign nssel  = cword_reg[1:0];
  assign dbin   = cword_reg[6:2];
  assign ctl    = cword_reg[15:8];
  assign valid  = valid_reg;
  assign halt   = (mode_reg == MODE_HALT);
  assign ucount = ucount_reg;

endmodule

// File: tb/tb_useq_ctrl.sv
// Testbench for useq_ctrl: a table of per-cycle vectors with hand-derived
// expectations, plus a generated saturation run. Expectations are queued
// when a cycle is driven and popped/compared after the clock edge.
module tb_useq_ctrl;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [4:0]  nextst;
  logic        cs_we;
  logic [4:0]  cs_waddr;
  logic [15:0] cs_wdata;
  logic [4:0]  state;
  logic [15:0] cword;
  logic [1:0]  nssel;
  logic [4:0]  dbin;
  logic [7:0]  ctl;
  logic        valid;
  logic        halt;
  logic [7:0]  ucount;

  useq_ctrl dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .nextst   (nextst),
    .cs_we    (cs_we),
    .cs_waddr (cs_waddr),
    .cs_wdata (cs_wdata),
    .state    (state),
    .cword    (cword),
    .nssel    (nssel),
    .dbin     (dbin),
    .ctl      (ctl),
    .valid    (valid),
    .halt     (halt),
    .ucount   (ucount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stl;
    logic [4:0]  nst;
    logic        we;
    logic [4:0]  wa;
    logic [15:0] wd;
    logic [4:0]  e_state;
    logic [15:0] e_cword;
    logic        e_valid;
    logic        e_halt;
    logic [7:0]  e_ucnt;
  } vec_t;

  typedef struct {
    logic [4:0]  e_state;
    logic [15:0] e_cword;
    logic        e_valid;
    logic        e_halt;
    logic [7:0]  e_ucnt;
  } exp_t;

  localparam int NVEC = 29;
  vec_t tbl [NVEC];
  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   txn    = 0;
  logic [15:0] exp_store [0:3];

  function automatic vec_t mk(input logic rst, input logic stl, input logic [4:0] nst,
                              input logic we, input logic [4:0] wa, input logic [15:0] wd,
                              input logic [4:0] es, input logic [15:0] ec, input logic ev,
                              input logic eh, input logic [7:0] eu);
    vec_t v;
    v.rst = rst; v.stl = stl; v.nst = nst; v.we = we; v.wa = wa; v.wd = wd;
    v.e_state = es; v.e_cword = ec; v.e_valid = ev; v.e_halt = eh; v.e_ucnt = eu;
    return v;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s txn=%0d got=%h expected=%h", name, txn, act, exp);
    end
  endtask

  // Pop the oldest expectation and compare every output against it.
  task automatic check_out();
    exp_t e;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty txn=%0d got=0 expected=1", txn);
      return;
    end
    e = sb_q.pop_front();
    chk("state",  {11'd0, state},  {11'd0, e.e_state});
    chk("cword",  cword,           e.e_cword);
    chk("nssel",  {14'd0, nssel},  {14'd0, e.e_cword[1:0]});
    chk("dbin",   {11'd0, dbin},   {11'd0, e.e_cword[6:2]});
    chk("ctl",    {8'd0, ctl},     {8'd0, e.e_cword[15:8]});
    chk("valid",  {15'd0, valid},  {15'd0, e.e_valid});
    chk("halt",   {15'd0, halt},   {15'd0, e.e_halt});
    chk("ucount", {8'd0, ucount},  {8'd0, e.e_ucnt});
  endtask

  // Drive one cycle, queue its expectation, then compare after the edge.
  task automatic run_cycle(input vec_t v);
    exp_t e;
    reset    = v.rst;
    stall    = v.stl;
    nextst   = v.nst;
    cs_we    = v.we;
    cs_waddr = v.wa;
    cs_wdata = v.wd;
    e.e_state = v.e_state;
    e.e_cword = v.e_cword;
    e.e_valid = v.e_valid;
    e.e_halt  = v.e_halt;
    e.e_ucnt  = v.e_ucnt;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    txn++;
    $display("txn %0d rst=%0b stl=%0b nst=%0d we=%0b | state=%0d cword=%h valid=%0b halt=%0b ucount=%0d",
             txn, v.rst, v.stl, v.nst, v.we, state, cword, valid, halt, ucount);
    check_out();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog txn=%0d got=timeout expected=finish", txn);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; stall = 1'b0; nextst = 5'd0;
    cs_we = 1'b0; cs_waddr = 5'd0; cs_wdata = 16'h0000;

    exp_store[0] = 16'h1A01;
    exp_store[1] = 16'h2108;
    exp_store[2] = 16'h420C;
    exp_store[3] = 16'h8312;

    //               rst  stl  nst   we   wa     wd        state  cword     v     h     ucnt
    // preload under reset: writes complete, outputs held at reset values
    tbl[0]  = mk(1'b1,1'b0,5'd0,1'b1,5'd0,16'h1A01, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    tbl[1]  = mk(1'b1,1'b0,5'd0,1'b1,5'd1,16'h2108, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    tbl[2]  = mk(1'b1,1'b0,5'd0,1'b1,5'd2,16'h420C, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    tbl[3]  = mk(1'b1,1'b0,5'd0,1'b1,5'd3,16'h8312, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    tbl[4]  = mk(1'b1,1'b0,5'd0,1'b1,5'd4,16'h0080, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    tbl[5]  = mk(1'b1,1'b0,5'd0,1'b1,5'd5,16'h1111, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    // reset bubble ends: store[0] loaded, not yet counted
    tbl[6]  = mk(1'b0,1'b0,5'd0,1'b0,5'd0,16'h0000, 5'd0,16'h1A01,1'b1,1'b0,8'd0);
    tbl[7]  = mk(1'b0,1'b0,5'd1,1'b0,5'd0,16'h0000, 5'd1,16'h2108,1'b1,1'b0,8'd1);
    tbl[8]  = mk(1'b0,1'b0,5'd2,1'b0,5'd0,16'h0000, 5'd2,16'h420C,1'b1,1'b0,8'd2);
    // three stalled cycles, with a control-store write during the first
    tbl[9]  = mk(1'b0,1'b1,5'd3,1'b1,5'd6,16'h5A5A, 5'd2,16'h420C,1'b1,1'b0,8'd2);
    tbl[10] = mk(1'b0,1'b1,5'd3,1'b0,5'd0,16'h0000, 5'd2,16'h420C,1'b1,1'b0,8'd2);
    tbl[11] = mk(1'b0,1'b1,5'd3,1'b0,5'd0,16'h0000, 5'd2,16'h420C,1'b1,1'b0,8'd2);
    tbl[12] = mk(1'b0,1'b0,5'd3,1'b0,5'd0,16'h0000, 5'd3,16'h8312,1'b1,1'b0,8'd3);
    tbl[13] = mk(1'b0,1'b0,5'd6,1'b0,5'd0,16'h0000, 5'd6,16'h5A5A,1'b1,1'b0,8'd4);
    tbl[14] = mk(1'b0,1'b0,5'd4,1'b0,5'd0,16'h0000, 5'd4,16'h0080,1'b1,1'b0,8'd5);
    // halt edge counts the halting word; afterwards nothing moves
    tbl[15] = mk(1'b0,1'b0,5'd1,1'b0,5'd0,16'h0000, 5'd4,16'h0080,1'b1,1'b1,8'd6);
    tbl[16] = mk(1'b0,1'b1,5'd2,1'b0,5'd0,16'h0000, 5'd4,16'h0080,1'b1,1'b1,8'd6);
    tbl[17] = mk(1'b0,1'b0,5'd3,1'b0,5'd0,16'h0000, 5'd4,16'h0080,1'b1,1'b1,8'd6);
    tbl[18] = mk(1'b1,1'b0,5'd7,1'b0,5'd0,16'h0000, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    // write bypass on an advance edge
    tbl[19] = mk(1'b0,1'b0,5'd0,1'b0,5'd0,16'h0000, 5'd0,16'h1A01,1'b1,1'b0,8'd0);
    tbl[20] = mk(1'b0,1'b0,5'd5,1'b1,5'd5,16'hBEEF, 5'd5,16'hBEEF,1'b1,1'b0,8'd1);
    tbl[21] = mk(1'b0,1'b0,5'd0,1'b0,5'd0,16'h0000, 5'd5,16'hBEEF,1'b1,1'b1,8'd2);
    tbl[22] = mk(1'b1,1'b0,5'd0,1'b0,5'd0,16'h0000, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    tbl[23] = mk(1'b0,1'b0,5'd5,1'b0,5'd0,16'h0000, 5'd5,16'hBEEF,1'b1,1'b0,8'd0);
    // reset while stalled with a concurrent write, then a stalled bubble
    tbl[24] = mk(1'b1,1'b1,5'd5,1'b1,5'd5,16'h1111, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    tbl[25] = mk(1'b0,1'b1,5'd5,1'b0,5'd0,16'h0000, 5'd0,16'h0000,1'b0,1'b0,8'd0);
    tbl[26] = mk(1'b0,1'b0,5'd5,1'b0,5'd0,16'h0000, 5'd5,16'h1111,1'b1,1'b0,8'd0);
    // write to another address does not bypass
    tbl[27] = mk(1'b0,1'b0,5'd1,1'b1,5'd7,16'h0203, 5'd1,16'h2108,1'b1,1'b0,8'd1);
    tbl[28] = mk(1'b0,1'b0,5'd7,1'b0,5'd0,16'h0000, 5'd7,16'h0203,1'b1,1'b0,8'd2);

    for (int i = 0; i < NVEC; i++) begin
      run_cycle(tbl[i]);
    end

    // Saturation: reset, then 300 advances over the halt-free words 0..3.
    run_cycle(mk(1'b1,1'b0,5'd0,1'b0,5'd0,16'h0000, 5'd0,16'h0000,1'b0,1'b0,8'd0));
    for (int k = 1; k <= 300; k++) begin
      logic [4:0] n;
      logic [7:0] eu;
      n  = 5'(k % 4);
      eu = ((k - 1) > 255) ? 8'd255 : 8'(k - 1);
      run_cycle(mk(1'b0,1'b0,n,1'b0,5'd0,16'h0000, n,exp_store[k % 4],1'b1,1'b0,eu));
    end
    // held at 255 through stalls and further advances
    for (int k = 0; k < 3; k++) begin
      run_cycle(mk(1'b0,1'b1,5'd2,1'b0,5'd0,16'h0000, 5'd0,16'h1A01,1'b1,1'b0,8'd255));
    end
    run_cycle(mk(1'b0,1'b0,5'd1,1'b0,5'd0,16'h0000, 5'd1,16'h2108,1'b1,1'b0,8'd255));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/useq_ctrl.md
USEQ_CTRL -- requirements
Module: useq_ctrl

Interface
REQ-001 The block SHALL have exactly the ports listed below, with clock and reset first.
REQ-002 clk  input  1  single system clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 stall  input  1  1 = hold state, cword and counter this cycle.
REQ-005 nextst  input  5  next micro-state from next-state logic.
REQ-006 cs_we  input  1  control-store write enable.
REQ-007 cs_waddr  input  5  control-store write address.
REQ-008 cs_wdata  input  16  control-store write data.
REQ-009 state  output  5  current micro-state (micro-PC).
REQ-010 cword  output  16  registered control word for the current state.
REQ-011 nssel  output  2  cword[1:0], next-state select to next-state logic.
REQ-012 dbin  output  5  cword[6:2], direct branch address to next-state logic.
REQ-013 ctl  output  8  cword[15:8], datapath control bits.
REQ-014 valid  output  1  1 = cword holds a control-store word, not the reset bubble.
REQ-015 halt  output  1  1 = sequencer halted.
REQ-016 ucount  output  8  count of executed microinstructions, saturating.

Function
REQ-017 Control store SHALL be 32 x 16 bits, written synchronously when cs_we=1 at cs_waddr; contents not affected by reset.
REQ-018 Cycle classes: advance = !reset && !halt && !stall; hold = otherwise (non-reset).
REQ-019 On advance: state <= nextst; cword <= store[nextst]; valid <= 1.
REQ-020 Write bypass: on advance with cs_we=1 and cs_waddr==nextst, cword SHALL take cs_wdata, not the old store word.
REQ-021 On hold: state, cword, valid, ucount SHALL keep their values; control-store writes still take effect.
REQ-022 cword[7] is the halt bit: halt SHALL set at the edge where a valid cword with bit7=1 is present and stall=0; the halted cword is counted in ucount.
REQ-023 Once set, halt SHALL remain 1 until reset; stall has no effect while halted.
REQ-024 ucount SHALL increment by 1 on every advance edge where valid=1 before the edge; at 255 it SHALL stay 255.
REQ-025 nssel, dbin, ctl SHALL be pure slices of cword (no extra latency).
REQ-026 Priority: reset > halt > stall > advance.
REQ-027 One-cycle latency: nextst sampled at edge n appears on state and cword after edge n.

Reset
REQ-028 At a clk edge with reset=1: state=0, cword=16'h0000, valid=0, halt=0, ucount=0.
REQ-029 Reset mid-operation (including while halted or stalled) SHALL take effect at that edge regardless of other inputs; a concurrent cs_we write still completes.
REQ-030 After reset, cword=0 gives nssel=00, dbin=0, so the first advance loads store[0] (one bubble cycle, valid=0).

Verification
REQ-031 Reset bubble: load store[0]=16'h1A01, reset, release, drive nextst from cword[6:2] -> cycle 1 valid=0 cword=0; cycle 2 state=0 cword=1A01 valid=1 ucount=0.
REQ-032 Sequence: store[0..3] chained via dbin, drive nextst=1,2,3 -> state 1,2,3 on consecutive edges; ucount increments 1,2,3.
REQ-033 Stall: assert stall 3 cycles mid-sequence -> state, cword, ucount frozen 3 cycles, resume with the same nextst.
REQ-034 Bypass: cs_we=1, cs_waddr=5, cs_wdata=16'hBEEF with nextst=5 on an advance edge -> cword=BEEF next cycle and store[5]=BEEF afterwards.
REQ-035 Halt: store[4]=16'h0080, advance to state 4 -> next edge halt=1; further nextst/stall changes leave state=4, ucount unchanged; reset clears halt=0, state=0.
REQ-036 Saturation: run 300 advances -> ucount=255 and held.
